// File: rtl/dmem_pkg.sv
// Shared encodings for the MEM-stage data memory controller: access sizes,
// controller FSM states and the wait-state limit.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam int MAX_WAIT_STATES = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte-enables and replicated write data,
// and load lane extraction with sign/zero extension.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_lane,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rword[7:0];
        case (i_lane)
            2'd0:    w_byte = i_rword[7:0];
            2'd1:    w_byte = i_rword[15:8];
            2'd2:    w_byte = i_rword[23:16];
            default: w_byte = i_rword[31:24];
        endcase
    end

    assign w_half = i_lane[1] ? i_rword[31:16] : i_rword[15:0];

    // Write data is replicated across lanes so the enables alone pick the target.
    always_comb begin
        o_be    = 4'b0000;
        o_wdata = i_wdata;
        o_rdata = 32'd0;
        case (i_size)
            SZ_BYTE: begin
                o_be    = 4'b0001 << i_lane;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            end
            SZ_HALF: begin
                o_be    = i_lane[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {{16{~i_unsigned & w_half[15]}}, w_half};
            end
            SZ_WORD: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
                o_rdata = i_rword;
            end
            default: begin
                o_be    = 4'b0000;
                o_rdata = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/d_mem_ctrl.sv
// Registered MEM-stage data memory: one access in flight, WAIT_STATES busy cycles,
// Ready/MemError pulse on completion. Define DMEM_BOUNDS_EN to reject addresses >= 4*SIZE.
module d_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int SIZE        = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [1:0]  MemSize,
    input  logic        MemUnsigned,
    output logic [31:0] ReadData,
    output logic        Ready,
    output logic        MemError,
    output logic [1:0]  o_dbg_state
);

    localparam int         AW = $clog2(SIZE);
    localparam logic [3:0] WS = 4'(WAIT_STATES);
`ifdef DMEM_BOUNDS_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    state_t        r_state;
    state_t        w_next;
    logic [3:0]    r_cnt;
    logic [AW+1:0] r_addr;
    logic [31:0]   r_wdata;
    logic [1:0]    r_size;
    logic          r_uns;
    logic          r_write;
    logic          r_read;
    logic          r_err;
    logic [31:0]   r_rdata;
    logic          r_ready;
    logic          r_memerr;
    logic [31:0]   r_mem [SIZE];

    logic          w_req;
    logic          w_oob;
    logic          w_err_in;
    logic          w_done;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_rword;
    logic [3:0]    w_be;
    logic [31:0]   w_wsh;
    logic [31:0]   w_load;

    assign w_req    = MemRead | MemWrite;
    assign w_oob    = BOUNDS_EN && ((Address >> (AW + 2)) != 32'd0);
    assign w_err_in = (MemRead & MemWrite)
                    | (MemSize == SZ_RSVD)
                    | ((MemSize == SZ_HALF) & Address[0])
                    | ((MemSize == SZ_WORD) & (Address[1:0] != 2'b00))
                    | w_oob;

    assign w_done  = (r_state == ST_BUSY) && (r_cnt == 4'd0);
    assign w_idx   = r_addr[AW+1:2];
    assign w_rword = r_mem[w_idx];

    dmem_lane_align u_align (
        .i_size     (r_size),
        .i_lane     (r_addr[1:0]),
        .i_unsigned (r_uns),
        .i_wdata    (r_wdata),
        .i_rword    (w_rword),
        .o_be       (w_be),
        .o_wdata    (w_wsh),
        .o_rdata    (w_load)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_req) w_next = ST_BUSY;
            ST_BUSY: if (r_cnt == 4'd0) w_next = ST_RESP;
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Request is latched once in IDLE; the error verdict is decided from the live inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= 4'd0;
            r_addr   <= '0;
            r_wdata  <= 32'd0;
            r_size   <= SZ_BYTE;
            r_uns    <= 1'b0;
            r_write  <= 1'b0;
            r_read   <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= 32'd0;
            r_ready  <= 1'b0;
            r_memerr <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && w_req) begin
                r_cnt   <= WS;
                r_addr  <= Address[AW+1:0];
                r_wdata <= WriteData;
                r_size  <= MemSize;
                r_uns   <= MemUnsigned;
                r_write <= MemWrite;
                r_read  <= MemRead;
                r_err   <= w_err_in;
            end else if (r_state == ST_BUSY && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_done && r_read) begin
                r_rdata <= r_err ? 32'd0 : w_load;
            end
            r_ready  <= (r_state == ST_RESP);
            r_memerr <= (r_state == ST_RESP) && r_err;
        end
    end

    // No reset on the array; an aborted store never reaches w_done because reset forces IDLE.
    always_ff @(posedge clk) begin
        if (w_done && r_write && !r_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wsh[8*i +: 8];
            end
        end
    end

    assign ReadData    = r_rdata;
    assign Ready       = r_ready;
    assign MemError    = r_memerr;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_d_mem_ctrl.sv
// Directed bench for d_mem_ctrl: one instance with WAIT_STATES=0 and one with 3,
// selected by sel; expected values are hand-computed constants.
module tb_d_mem_ctrl;
    import dmem_pkg::*;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst3, sel, toggle;
    logic [31:0] addr, wdata;
    logic        wr, rd, uns;
    logic [1:0]  sz;

    logic [31:0] rdata0, rdata3, rdata;
    logic        rdy0, rdy3, err0, err3, rdy, err;
    logic [1:0]  st0, st3;

    assign rdata = sel ? rdata3 : rdata0;
    assign rdy   = sel ? rdy3 : rdy0;
    assign err   = sel ? err3 : err0;

    d_mem_ctrl #(.SIZE(1024), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(rst0), .Address(addr), .WriteData(wdata),
        .MemWrite(wr & ~sel), .MemRead(rd & ~sel), .MemSize(sz), .MemUnsigned(uns),
        .ReadData(rdata0), .Ready(rdy0), .MemError(err0), .o_dbg_state(st0)
    );

    d_mem_ctrl #(.SIZE(1024), .WAIT_STATES(3)) dut3 (
        .clk(clk), .reset(rst3), .Address(addr), .WriteData(wdata),
        .MemWrite(wr & sel), .MemRead(rd & sel), .MemSize(sz), .MemUnsigned(uns),
        .ReadData(rdata3), .Ready(rdy3), .MemError(err3), .o_dbg_state(st3)
    );

    // scoreboard
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    // driver: called at a negedge with the DUT idle; returns after the Ready pulse ends
    task automatic access(input bit w, input bit r, input logic [1:0] s, input bit u,
                          input logic [31:0] a, input logic [31:0] d, input bit exp_err,
                          input string tag, output logic [31:0] got_data);
        int exp_lat;
        int lat;
        bit got;
        exp_lat  = sel ? 5 : 2;
        lat      = 0;
        got      = 1'b0;
        got_data = 32'd0;
        addr = a; wdata = d; sz = s; uns = u; wr = w; rd = r;
        @(posedge clk);
        @(negedge clk);
        wr = 1'b0; rd = 1'b0;
        while (lat < 40 && !got) begin
            if (rdy) begin
                got = 1'b1;
                wr  = 1'b0;
                rd  = 1'b0;
            end else begin
                if (toggle) begin
                    addr  = $urandom;
                    wdata = $urandom;
                    sz    = 2'($urandom_range(0, 3));
                    uns   = 1'($urandom_range(0, 1));
                    wr    = 1'($urandom_range(0, 1));
                    rd    = 1'($urandom_range(0, 1));
                end
                @(posedge clk);
                @(negedge clk);
                lat++;
            end
        end
        wr = 1'b0; rd = 1'b0;
        check({tag, "_lat"}, got ? lat : -1, exp_lat);
        check({tag, "_err"}, err, exp_err);
        got_data = rdata;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_pulse"}, rdy, 1'b0);
    endtask

    task automatic st(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d,
                      input bit exp_err, input string tag);
        logic [31:0] dummy;
        access(1'b1, 1'b0, s, 1'b0, a, d, exp_err, tag, dummy);
    endtask

    task automatic ld(input logic [1:0] s, input bit u, input logic [31:0] a,
                      input logic [31:0] exp, input bit exp_err, input string tag);
        logic [31:0] got;
        exp_q.push_back(exp);
        access(1'b0, 1'b1, s, u, a, 32'd0, exp_err, tag, got);
        check({tag, "_data"}, got, exp_q.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        rst0 = 1'b1; rst3 = 1'b1; sel = 1'b0; toggle = 1'b0;
        addr = 32'd0; wdata = 32'd0; wr = 1'b0; rd = 1'b0; sz = SZ_WORD; uns = 1'b0;
        repeat (3) @(negedge clk);
        rst0 = 1'b0; rst3 = 1'b0;
        @(negedge clk);
        check("rst_ready0", rdy0, 1'b0);
        check("rst_err0", err0, 1'b0);
        check("rst_rdata0", rdata0, 32'd0);
        check("rst_state0", st0, ST_IDLE);
        check("rst_state3", st3, ST_IDLE);

        // basic word store/load, WAIT_STATES=0
        st(SZ_WORD, 32'h10, 32'hDEADBEEF, 1'b0, "t1_sw");
        ld(SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, "t1_lw");

        // sub-word access and extension
        st(SZ_BYTE, 32'h11, 32'h000000AA, 1'b0, "t2_sb");
        ld(SZ_BYTE, 1'b0, 32'h11, 32'hFFFFFFAA, 1'b0, "t2_lb");
        ld(SZ_BYTE, 1'b1, 32'h11, 32'h000000AA, 1'b0, "t2_lbu");
        ld(SZ_WORD, 1'b0, 32'h10, 32'hDEADAAEF, 1'b0, "t2_lw");
        st(SZ_WORD, 32'h18, 32'h00000005, 1'b0, "t2_sw18");
        check("t2_hold", rdata0, 32'hDEADAAEF);
        ld(SZ_HALF, 1'b0, 32'h12, 32'hFFFFDEAD, 1'b0, "t2_lh");
        ld(SZ_HALF, 1'b1, 32'h12, 32'h0000DEAD, 1'b0, "t2_lhu");
        ld(SZ_BYTE, 1'b0, 32'h10, 32'hFFFFFFEF, 1'b0, "t2_lb0");
        ld(SZ_BYTE, 1'b1, 32'h13, 32'h000000DE, 1'b0, "t2_lbu3");
        st(SZ_WORD, 32'h14, 32'h00000000, 1'b0, "t2_sw14");
        st(SZ_HALF, 32'h16, 32'h12347F80, 1'b0, "t2_sh");
        ld(SZ_WORD, 1'b0, 32'h14, 32'h7F800000, 1'b0, "t2_lw14");
        ld(SZ_HALF, 1'b0, 32'h16, 32'h00007F80, 1'b0, "t2_lh16");
        ld(SZ_BYTE, 1'b0, 32'h17, 32'h0000007F, 1'b0, "t2_lb17");

        // error cases
        ld(SZ_HALF, 1'b0, 32'h13, 32'd0, 1'b1, "t3_lh_mis");
        ld(SZ_WORD, 1'b0, 32'h12, 32'd0, 1'b1, "t3_lw_mis");
        ld(SZ_RSVD, 1'b0, 32'h10, 32'd0, 1'b1, "t3_rsvd");
        st(SZ_WORD, 32'h12, 32'hFFFFFFFF, 1'b1, "t3_sw_mis");
        st(SZ_HALF, 32'h11, 32'hFFFFFFFF, 1'b1, "t3_sh_mis");
        access(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hFFFFFFFF, 1'b1, "t3_rw", got);
        check("t3_rw_data", got, 32'd0);
        ld(SZ_WORD, 1'b0, 32'h10, 32'hDEADAAEF, 1'b0, "t3_lw_keep");

        // address wrap (default build has no bounds checking)
        st(SZ_WORD, 32'h1000, 32'h00001234, 1'b0, "t6_sw");
        ld(SZ_WORD, 1'b0, 32'h0, 32'h00001234, 1'b0, "t6_lw");

        // WAIT_STATES=3 with input noise during the access
        sel = 1'b1;
        toggle = 1'b1;
        st(SZ_WORD, 32'h40, 32'hA5A55A5A, 1'b0, "t4_sw");
        ld(SZ_WORD, 1'b0, 32'h40, 32'hA5A55A5A, 1'b0, "t4_lw");
        toggle = 1'b0;
        ld(SZ_WORD, 1'b0, 32'h40, 32'hA5A55A5A, 1'b0, "t4_lw2");

        // reset during a pending store
        st(SZ_WORD, 32'h20, 32'h11111111, 1'b0, "t5_sw_old");
        ld(SZ_WORD, 1'b0, 32'h20, 32'h11111111, 1'b0, "t5_lw_old");
        addr = 32'h20; wdata = 32'h22222222; sz = SZ_WORD; uns = 1'b0; wr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wr = 1'b0;
        check("t5_busy", st3, ST_BUSY);
        rst3 = 1'b1;
        #1;
        check("t5_rst_rdata", rdata3, 32'd0);
        check("t5_rst_ready", rdy3, 1'b0);
        check("t5_rst_err", err3, 1'b0);
        check("t5_rst_state", st3, ST_IDLE);
        @(negedge clk);
        rst3 = 1'b0;
        @(negedge clk);
        ld(SZ_WORD, 1'b0, 32'h20, 32'h11111111, 1'b0, "t5_lw_after");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
